binary_add_pipe: RTL

Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the team's fixed 3-bit registered adder, generalised to WIDTH bits with the carry chain split into STAGES registered segments. It adds carry-in/carry-out, subtract mode, signed-overflow detection and a valid flag that travels with the data. It sits in the datapath wherever a wide add must close timing at clk rate, accepting one operation per enabled cycle.

---
 rtl/binary_add_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/binary_add_pipe.sv
// binary_add_pipe: pipelined ripple-carry adder/subtractor.
//   {cout, S} = A + (sub ? ~B : B) + (cin ^ sub), carry chain cut into
//   STAGES registered segments of SEG = WIDTH/STAGES bits each.
// Ports:
//   clk, rst_n      clock (rising) / async active-low reset
//   en              pipeline advance; 0 freezes every register
//   in_valid        A/B/cin/sub carry a real operation this cycle
//   A, B, cin, sub  operands, carry-in, subtract select
//   S, cout, ovf    registered result, carry out of MSB, signed overflow
//   out_valid       S/cout/ovf belong to a valid operation
// Latency is STAGES enabled edges, counting the sampling edge.

// One carry-chain segment. Sums bits [K*SEG +: SEG] of the operands plus the
// incoming carry, merges them into the partial sum, and registers the whole
// slot (operands, partial sum, carry) so the next segment sees a coherent op.
module binary_add_seg #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ov_o
);
  localparam int LO = K * SEG;

  logic [SEG-1:0]   sum;
  logic             co;
  logic             cm;
  logic [WIDTH-1:0] s_nxt;

  assign {co, sum} = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]}
                   + {{SEG{1'b0}}, c_i};
  // carry into this segment's top bit, recovered from the sum bit
  assign cm = a_i[LO+SEG-1] ^ b_i[LO+SEG-1] ^ sum[SEG-1];

  always_comb begin
    s_nxt = s_i;
    s_nxt[LO +: SEG] = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o  <= '0;
      b_o  <= '0;
      s_o  <= '0;
      c_o  <= 1'b0;
      ov_o <= 1'b0;
    end else if (en) begin
      a_o  <= a_i;
      b_o  <= b_i;
      s_o  <= s_nxt;
      c_o  <= co;
      // only meaningful for the top segment, where it is the word's ovf
      ov_o <= co ^ cm;
    end
  end
endmodule

module binary_add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);
  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("binary_add_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // index k = slot entering segment k; index STAGES = output registers
  logic [STAGES:0][WIDTH-1:0] a_p, b_p, s_p;
  logic [STAGES:0]            c_p, ov_p;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES-1:0]          vld_q;

  assign a_p[0]  = A;
  assign b_p[0]  = sub ? ~B : B;
  assign s_p[0]  = '0;
  assign c_p[0]  = cin ^ sub;
  assign ov_p[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    binary_add_seg #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .a_i  (a_p[k]),
      .b_i  (b_p[k]),
      .s_i  (s_p[k]),
      .c_i  (c_p[k]),
      .a_o  (a_p[k+1]),
      .b_o  (b_p[k+1]),
      .s_o  (s_p[k+1]),
      .c_o  (c_p[k+1]),
      .ov_o (ov_p[k+1])
    );
  end

  // valid bit rides alongside the data slots
  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];
  end

  assign S         = s_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = ov_p[STAGES];
  assign out_valid = vld_pipe[STAGES];

  // operands past the last segment and lower-segment overflow flags are dead
  logic unused_tail;
  assign unused_tail = ^{a_p[STAGES], b_p[STAGES], ov_p[STAGES-1:0]};
endmodule
